// File: rtl/riscv_v_rf_mp_if.sv
// Signal bundle for the multi-port vector register file.
// It carries the write request, the packed read ports, and the clear/status outputs.
interface riscv_v_rf_mp_if #(
   parameter int DATA_W       = 128,
   parameter int NUM_REGS     = 32,
   parameter int NUM_RD_PORTS = 3
);
   localparam int AW = $clog2(NUM_REGS);
   localparam int NB = DATA_W / 8;

   logic                           clr_req;
   logic                           wr_valid;
   logic                           wr_ready;
   logic [AW-1:0]                  wr_addr;
   logic [NB-1:0]                  wr_be;
   logic [DATA_W-1:0]              wr_data;
   logic [NUM_RD_PORTS*AW-1:0]     rd_addr;
   logic [NUM_RD_PORTS*DATA_W-1:0] rd_data;
   logic [DATA_W-1:0]              mask;
   logic                           busy;
   logic                           clr_done;

   modport master (
      output clr_req, wr_valid, wr_addr, wr_be, wr_data, rd_addr,
      input  wr_ready, rd_data, mask, busy, clr_done
   );

   modport slave (
      input  clr_req, wr_valid, wr_addr, wr_be, wr_data, rd_addr,
      output wr_ready, rd_data, mask, busy, clr_done
   );
endinterface

// File: rtl/riscv_v_rf_mp.sv
// Multi-port vector register file.
// - One byte-enabled write port and NUM_RD_PORTS combinational read ports.
// - Register 0 is also exposed on the mask output.
// - A CLEAR state zeroes the storage one register per cycle.
//   It runs after reset and on clr_req, and hides all read data while it runs.
module riscv_v_rf_mp #(
   parameter int DATA_W       = 128,
   parameter int NUM_REGS     = 32,
   parameter int NUM_RD_PORTS = 3,
   parameter int USE_BYPASS   = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   riscv_v_rf_mp_if.slave  rf
);
   localparam int AW        = $clog2(NUM_REGS);
   localparam int NB        = DATA_W / 8;
   localparam bit BYPASS_EN = (USE_BYPASS != 0);
   localparam logic [AW-1:0] LAST_REG = AW'(NUM_REGS - 1);

   typedef enum logic {
      CLEAR,
      READY
   } state_e;

   state_e            state;
   state_e            state_nxt;
   logic [AW-1:0]     clr_cnt;
   logic [AW-1:0]     clr_cnt_nxt;
   logic              clr_done_q;
   logic              clr_done_nxt;
   logic              busy_i;
   logic              wr_fire;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] mask_word;

   // Replace the enabled bytes of a stored word with the incoming write data.
   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] stored,
      input logic [NB-1:0]     be,
      input logic [DATA_W-1:0] data
   );
      logic [DATA_W-1:0] res;
      res = stored;
      for (int b = 0; b < NB; b++) begin
         if (be[b]) res[b*8 +: 8] = data[b*8 +: 8];
      end
      return res;
   endfunction

   assign busy_i      = (state == CLEAR);
   assign wr_fire     = rf.wr_valid && (state == READY);
   assign rf.busy     = busy_i;
   assign rf.wr_ready = (state == READY);
   assign rf.clr_done = clr_done_q;

   // State, clear counter and completion pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= CLEAR;
         clr_cnt    <= '0;
         clr_done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state      <= state_nxt;
         clr_cnt    <= clr_cnt_nxt;
         clr_done_q <= clr_done_nxt;
      end
   end

   // Next-state logic: walk the clear counter, or start a clear on request.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_nxt    = state;
      clr_cnt_nxt  = clr_cnt;
      clr_done_nxt = 1'b0;
      case (state)
         CLEAR: begin
            // clr_req is deliberately ignored here so a clear is never extended.
            if (clr_cnt == LAST_REG) begin
               state_nxt    = READY;
               clr_cnt_nxt  = '0;
               clr_done_nxt = 1'b1;
            end else begin
               clr_cnt_nxt = clr_cnt + AW'(1);
            end
         end
         READY: begin
            if (rf.clr_req) begin
               state_nxt   = CLEAR;
               clr_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt   = CLEAR;
            clr_cnt_nxt = '0;
         end
      endcase
   end

   // Storage update: zero one register per clear cycle, or commit an accepted write.
   // NOTE: storage has no reset; the CLEAR sequence zeroes it, so it maps onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (busy_i) begin
         regs[clr_cnt] <= '0;
      end else if (wr_fire) begin
         regs[rf.wr_addr] <= merge_bytes(regs[rf.wr_addr], rf.wr_be, rf.wr_data);
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      logic [AW-1:0]     addr;
      logic [DATA_W-1:0] word;

      assign addr = rf.rd_addr[p*AW +: AW];

      // Read mux for this port, with optional same-cycle forwarding and masking while clearing.
      always_comb begin
         word = regs[addr];
         if (BYPASS_EN && wr_fire && (rf.wr_addr == addr)) begin
            word = merge_bytes(regs[addr], rf.wr_be, rf.wr_data);
         end
         if (busy_i) word = '0;
      end

      assign rf.rd_data[p*DATA_W +: DATA_W] = word;
   end

   // Register 0 view on the mask output, with the same forwarding and masking rules as the read ports.
   always_comb begin
      mask_word = regs[0];
      if (BYPASS_EN && wr_fire && (rf.wr_addr == '0)) begin
         mask_word = merge_bytes(regs[0], rf.wr_be, rf.wr_data);
      end
      if (busy_i) mask_word = '0;
   end

   assign rf.mask = mask_word;
endmodule

// File: tb/tb_riscv_v_rf_mp.sv
// Testbench for riscv_v_rf_mp.
// - Two instances share the same stimulus: one with forwarding enabled, one without.
// - A behavioural model tracks register contents and the length of the clear window.
module tb_riscv_v_rf_mp;
   localparam int DW = 128;
   localparam int NR = 32;
   localparam int NP = 3;
   localparam int AW = 5;
   localparam int NB = 16;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   riscv_v_rf_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP)) bus ();
   riscv_v_rf_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP)) bus_nb ();

   riscv_v_rf_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP), .USE_BYPASS(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (bus)
   );

   riscv_v_rf_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP), .USE_BYPASS(0)) dut_nb (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (bus_nb)
   );

   assign bus_nb.clr_req  = bus.clr_req;
   assign bus_nb.wr_valid = bus.wr_valid;
   assign bus_nb.wr_addr  = bus.wr_addr;
   assign bus_nb.wr_be    = bus.wr_be;
   assign bus_nb.wr_data  = bus.wr_data;
   assign bus_nb.rd_addr  = bus.rd_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   logic [DW-1:0] m_mem [NR];
   logic          m_busy;
   logic          m_done;
   int            m_left;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b1;
      m_done = 1'b0;
      m_left = NR;
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
   endtask

   // Expected read value of register a, given the current inputs.
   function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
      logic [DW-1:0] v;
      if (m_busy) return '0;
      v = m_mem[a];
      if (byp && bus.wr_valid && (bus.wr_addr == a)) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.wr_be[b]) v[b*8 +: 8] = bus.wr_data[b*8 +: 8];
         end
      end
      return v;
   endfunction

   // Advance the model by one clock edge.
   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_done = 1'b0;
      if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
         end
      end else begin
         if (bus.wr_valid) begin
            for (int b = 0; b < NB; b++) begin
               if (bus.wr_be[b]) m_mem[bus.wr_addr][b*8 +: 8] = bus.wr_data[b*8 +: 8];
            end
         end
         if (bus.clr_req) begin
            m_busy = 1'b1;
            m_left = NR;
            for (int i = 0; i < NR; i++) m_mem[i] = '0;
         end
      end
   endtask

   task automatic check_all();
      logic [AW-1:0] a;
      chk("busy",        DW'(bus.busy),        DW'(m_busy));
      chk("wr_ready",    DW'(bus.wr_ready),    DW'(!m_busy));
      chk("clr_done",    DW'(bus.clr_done),    DW'(m_done));
      chk("mask",        bus.mask,             exp_read('0, 1'b1));
      chk("nb_busy",     DW'(bus_nb.busy),     DW'(m_busy));
      chk("nb_wr_ready", DW'(bus_nb.wr_ready), DW'(!m_busy));
      chk("nb_clr_done", DW'(bus_nb.clr_done), DW'(m_done));
      chk("nb_mask",     bus_nb.mask,          exp_read('0, 1'b0));
      for (int p = 0; p < NP; p++) begin
         a = bus.rd_addr[p*AW +: AW];
         chk($sformatf("rd%0d", p),    bus.rd_data[p*DW +: DW],    exp_read(a, 1'b1));
         chk($sformatf("nb_rd%0d", p), bus_nb.rd_data[p*DW +: DW], exp_read(a, 1'b0));
      end
   endtask

   task automatic sample();
      @(negedge clk);
      check_all();
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic cycle();
      sample();
      tick();
   endtask

   // Run until busy drops (bounded), optionally pulsing clr_req during the clear; return edges spent busy.
   task automatic run_clear(input bit poke_clr, output int n);
      n = 0;
      while (bus.busy && n < 100) begin
         bus.clr_req = poke_clr && (n >= 3) && (n < 6);
         cycle();
         n++;
      end
      bus.clr_req = 1'b0;
   endtask

   initial begin
      int            n;
      logic [DW-1:0] d;
      logic [DW-1:0] exp_lo;
      logic [AW-1:0] a;

      n_cmp = 0;
      n_err = 0;

      // Reset with a write request held.
      bus.clr_req  = 1'b0;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = '0;
      bus.wr_be    = '1;
      bus.wr_data  = '1;
      bus.rd_addr  = '0;
      rst_n        = 1'b0;
      model_reset();
      #1;
      check_all();
      repeat (2) cycle();
      #2;
      rst_n = 1'b1;

      // Initial clear: exactly NR busy cycles, then a one-cycle clr_done.
      run_clear(1'b0, n);
      chk("init_clear_len", DW'(n), DW'(NR));
      bus.wr_valid = 1'b0;
      sample();
      chk("clr_done_pulse", DW'(bus.clr_done), DW'(1));
      tick();
      for (int r = 0; r < NR; r++) begin
         a = AW'(r);
         bus.rd_addr = {a, a, a};
         cycle();
      end

      // Full write to register 0: mask forwarded now, non-forwarding instance only after the edge.
      bus.wr_valid = 1'b1;
      bus.wr_addr  = '0;
      bus.wr_be    = '1;
      bus.wr_data  = {DW{1'b1}};
      bus.rd_addr  = '0;
      sample();
      chk("mask_byp",      bus.mask,    {DW{1'b1}});
      chk("mask_nb_early", bus_nb.mask, '0);
      tick();
      bus.wr_valid = 1'b0;
      sample();
      chk("mask_nb_late", bus_nb.mask, {DW{1'b1}});
      tick();

      // Partial write to register 5, read on ports 0 and 2.
      exp_lo       = {64'h0, {8{8'hAA}}};
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 5'd5;
      bus.wr_be    = 16'h00FF;
      bus.wr_data  = {16{8'hAA}};
      bus.rd_addr  = {5'd5, 5'd1, 5'd5};
      sample();
      chk("r5_p0_same", bus.rd_data[0 +: DW],    exp_lo);
      chk("r5_p2_same", bus.rd_data[2*DW +: DW], exp_lo);
      tick();
      bus.wr_valid = 1'b0;
      sample();
      chk("r5_p0_after",    bus.rd_data[0 +: DW],    exp_lo);
      chk("r5_p2_after",    bus.rd_data[2*DW +: DW], exp_lo);
      chk("r5_nb_p0_after", bus_nb.rd_data[0 +: DW], exp_lo);
      tick();

      // A write with no byte enables leaves register 3 untouched.
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 5'd3;
      bus.wr_be    = '1;
      bus.wr_data  = 128'h1234;
      bus.rd_addr  = {5'd0, 5'd3, 5'd0};
      cycle();
      bus.wr_be   = '0;
      bus.wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      sample();
      chk("be0_same",  bus.rd_data[DW +: DW], 128'h1234);
      chk("be0_ready", DW'(bus.wr_ready),     DW'(1));
      tick();
      bus.wr_valid = 1'b0;
      sample();
      chk("be0_after",       bus.rd_data[DW +: DW], 128'h1234);
      chk("be0_ready_after", DW'(bus.wr_ready),     DW'(1));
      tick();

      // Write to register 7 on the clr_req edge; extra clr_req pulses during the clear.
      d            = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 5'd7;
      bus.wr_be    = '1;
      bus.wr_data  = d;
      bus.clr_req  = 1'b1;
      bus.rd_addr  = {5'd0, 5'd0, 5'd7};
      cycle();
      bus.wr_valid = 1'b0;
      bus.clr_req  = 1'b0;
      run_clear(1'b1, n);
      chk("clr_req_len", DW'(n), DW'(NR));
      sample();
      chk("r7_cleared", bus.rd_data[0 +: DW], '0);
      tick();

      // Reset asserted at clear cycle 10 with a write pending; the clear restarts in full.
      bus.clr_req = 1'b1;
      cycle();
      bus.clr_req = 1'b0;
      repeat (10) cycle();
      #2;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 5'd9;
      bus.wr_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rst_n        = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (2) cycle();
      #2;
      rst_n        = 1'b1;
      bus.wr_valid = 1'b0;
      run_clear(1'b0, n);
      chk("rst_mid_clear_len", DW'(n), DW'(NR));
      cycle();

      // Reset in the middle of a READY-state write: outputs drop at once, and the write is lost.
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 5'd9;
      bus.wr_be    = '1;
      bus.wr_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.rd_addr  = {5'd0, 5'd0, 5'd9};
      sample();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_busy",     DW'(bus.busy),     DW'(1));
      chk("rst_wr_ready", DW'(bus.wr_ready), DW'(0));
      chk("rst_clr_done", DW'(bus.clr_done), DW'(0));
      chk("rst_rd0",      bus.rd_data[0 +: DW], '0);
      chk("rst_mask",     bus.mask,          '0);
      tick();
      cycle();
      #2;
      rst_n        = 1'b1;
      bus.wr_valid = 1'b0;
      run_clear(1'b0, n);
      chk("rst_mid_write_len", DW'(n), DW'(NR));
      sample();
      chk("r9_discarded", bus.rd_data[0 +: DW], '0);
      tick();

      // Randomized traffic checked against the model every cycle.
      for (int i = 0; i < 400; i++) begin
         bus.wr_valid = ($urandom_range(0, 3) != 0);
         bus.wr_addr  = AW'($urandom_range(0, NR - 1));
         case ($urandom_range(0, 3))
            0:       bus.wr_be = '0;
            1:       bus.wr_be = '1;
            default: bus.wr_be = NB'($urandom());
         endcase
         bus.wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 1) != 0) bus.rd_addr[p*AW +: AW] = bus.wr_addr;
            else                           bus.rd_addr[p*AW +: AW] = AW'($urandom_range(0, NR - 1));
         end
         bus.clr_req = ($urandom_range(0, 63) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
